// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: detects the host start pulse on the open-drain data
// line, then answers with the response preamble and a 40-bit measurement
// frame using DHT11 pulse-width bit encoding.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | bus released, waiting for the host to pull the line low
// HOST_LOW | measuring the host low time (up-count, saturating)
// TURN     | bus released for the turnaround gap before responding
// RESP_L   | response preamble, low phase
// RESP_H   | response preamble, high phase
// BIT_L    | low slot preceding each data bit
// BIT_H    | high phase whose length encodes the current data bit
// END_L    | final low slot, then release and signal frame completion
module dht11_sensor_emu #(
  parameter int START_MIN_LOW = 1000000,
  parameter int TURN_DELAY    = 3000,
  parameter int RESP_LOW      = 8000,
  parameter int RESP_HIGH     = 8000,
  parameter int BIT_LOW       = 5000,
  parameter int BIT_HIGH_0    = 2700,
  parameter int BIT_HIGH_1    = 7000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dht11_data_i,
  output logic       dht11_data_o,
  output logic       dht11_data_o_en,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       err_inject,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, TURN, RESP_L, RESP_H, BIT_L, BIT_H, END_L
  } state_t;

  // Phase timers load (duration - 1) and expire when they reach zero, so each
  // timed state lasts exactly its configured number of cycles.
  localparam logic [20:0] T_START  = 21'(START_MIN_LOW - 1);
  localparam logic [20:0] T_TURN   = 21'(TURN_DELAY - 1);
  localparam logic [20:0] T_RESP_L = 21'(RESP_LOW - 1);
  localparam logic [20:0] T_RESP_H = 21'(RESP_HIGH - 1);
  localparam logic [20:0] T_BIT_L  = 21'(BIT_LOW - 1);
  localparam logic [20:0] T_BIT_H0 = 21'(BIT_HIGH_0 - 1);
  localparam logic [20:0] T_BIT_H1 = 21'(BIT_HIGH_1 - 1);
  localparam logic [20:0] T_MAX    = '1;
  localparam logic [5:0]  LAST_BIT = 6'd39;

  logic        sync_ff1;
  logic        sync;
  state_t      state,   state_nx;
  logic [20:0] timer,   timer_nx;
  logic [5:0]  bit_idx, bit_idx_nx;
  logic [39:0] frame,   frame_nx;
  logic        busy_nx;
  logic        done_nx;
  logic        o_nx;
  logic        oen_nx;
  logic        tc;
  logic [7:0]  sum_bytes;
  logic [7:0]  csum;
  logic [5:0]  bit_sel;
  logic        cur_bit;

  assign tc        = (timer == 21'd0);
  assign sum_bytes = hum_int + hum_dec + temp_int + temp_dec;
  assign csum      = err_inject ? ~sum_bytes : sum_bytes;
  assign bit_sel   = LAST_BIT - bit_idx;
  assign cur_bit   = frame[bit_sel];

  // Two-flop synchronizer; idles high like the pulled-up bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b1;
      sync     <= 1'b1;
    end else begin
      sync_ff1 <= dht11_data_i;
      sync     <= sync_ff1;
    end
  end

  // State, timer, frame and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      timer           <= '0;
      bit_idx         <= '0;
      frame           <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      dht11_data_o    <= 1'b1;
      dht11_data_o_en <= 1'b0;
    end else begin
      state           <= state_nx;
      timer           <= timer_nx;
      bit_idx         <= bit_idx_nx;
      frame           <= frame_nx;
      busy            <= busy_nx;
      frame_done      <= done_nx;
      dht11_data_o    <= o_nx;
      dht11_data_o_en <= oen_nx;
    end
  end

  // Next-state logic; pad outputs are decoded from the next state so the
  // registered drive lines up with the state register.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_idx_nx = bit_idx;
    frame_nx   = frame;
    busy_nx    = busy;
    done_nx    = 1'b0;
    o_nx       = 1'b1;
    oen_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (!sync) begin
          state_nx = HOST_LOW;
          timer_nx = '0;
        end
      end
      HOST_LOW: begin
        if (sync) begin
          if (timer >= T_START) begin
            state_nx = TURN;
            timer_nx = T_TURN;
            busy_nx  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (timer != T_MAX) begin
          timer_nx = timer + 21'd1;
        end
      end
      TURN: begin
        if (tc) begin
          state_nx = RESP_L;
          timer_nx = T_RESP_L;
          frame_nx = {hum_int, hum_dec, temp_int, temp_dec, csum};
        end else begin
          timer_nx = timer - 21'd1;
        end
      end
      RESP_L: begin
        if (tc) begin
          state_nx = RESP_H;
          timer_nx = T_RESP_H;
        end else begin
          timer_nx = timer - 21'd1;
        end
      end
      RESP_H: begin
        if (tc) begin
          state_nx   = BIT_L;
          timer_nx   = T_BIT_L;
          bit_idx_nx = '0;
        end else begin
          timer_nx = timer - 21'd1;
        end
      end
      BIT_L: begin
        if (tc) begin
          state_nx = BIT_H;
          timer_nx = cur_bit ? T_BIT_H1 : T_BIT_H0;
        end else begin
          timer_nx = timer - 21'd1;
        end
      end
      BIT_H: begin
        if (tc) begin
          timer_nx = T_BIT_L;
          if (bit_idx == LAST_BIT) begin
            state_nx = END_L;
          end else begin
            state_nx   = BIT_L;
            bit_idx_nx = bit_idx + 6'd1;
          end
        end else begin
          timer_nx = timer - 21'd1;
        end
      end
      END_L: begin
        if (tc) begin
          state_nx = IDLE;
          timer_nx = '0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          timer_nx = timer - 21'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    case (state_nx)
      RESP_L, BIT_L, END_L: begin
        oen_nx = 1'b1;
        o_nx   = 1'b0;
      end
      RESP_H, BIT_H: begin
        oen_nx = 1'b1;
        o_nx   = 1'b1;
      end
      default: begin
        oen_nx = 1'b0;
        o_nx   = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/dht11_sensor_emu.md
DHT11_SENSOR_EMU -- requirements
Module: dht11_sensor_emu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be as follows; all times are in clk cycles at 100 MHz:
- START_MIN_LOW, 1000000, minimum host low time that counts as a start (10 ms).
- TURN_DELAY, 3000, gap from host release to response (30 us).
- RESP_LOW, 8000, response low time (80 us).
- RESP_HIGH, 8000, response high time (80 us).
- BIT_LOW, 5000, low slot before each bit and end-of-frame low (50 us).
- BIT_HIGH_0, 2700, high time for a "0" bit (27 us).
- BIT_HIGH_1, 7000, high time for a "1" bit (70 us).
REQ-003 Ports SHALL be as follows:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- dht11_data_i  in  1  bus level sampled from the pad.
- dht11_data_o  out  1  level driven when enabled.
- dht11_data_o_en  out  1  1 = drive the bus, 0 = release it (pull-up).
- hum_int, hum_dec, temp_int, temp_dec  in  8 each  measurement bytes to report.
- err_inject  in  1  1 = send the bit-inverted checksum.
- busy  out  1  high from start detection until the frame ends.
- frame_done  out  1  one-cycle pulse when the frame ends.

Function
REQ-004 dht11_data_i SHALL pass through a two-flop synchronizer; all timing below refers to the synchronized level (sync).
REQ-005 States SHALL be IDLE, HOST_LOW, TURN, RESP_L, RESP_H, BIT_L, BIT_H, END_L.
REQ-006 IDLE: o_en=0; on sync=0 go to HOST_LOW and clear the timer.
REQ-007 HOST_LOW: the timer increments each cycle while sync=0.
- On sync=1 with timer >= START_MIN_LOW-1: go to TURN and set busy.
- On sync=1 with timer below that: return to IDLE (glitch); no drive, no busy.
REQ-008 Timer width SHALL be 21 bits and SHALL saturate at all-ones, never wrapping.
REQ-009 TURN: o_en=0 for TURN_DELAY cycles, then go to RESP_L.
REQ-010 On TURN->RESP_L the block SHALL snapshot the 40-bit frame {hum_int, hum_dec, temp_int, temp_dec, csum}.
- csum = (hum_int+hum_dec+temp_int+temp_dec) mod 256.
- csum is inverted if err_inject=1 at that cycle.
- Input changes after the snapshot SHALL NOT affect the frame.
REQ-011 RESP_L SHALL drive o_en=1, o=0 for RESP_LOW cycles. RESP_H SHALL drive o_en=1, o=1 for RESP_HIGH cycles.
REQ-012 Each bit SHALL be BIT_L then BIT_H, sent MSB first (frame bit 39 first).
- BIT_L: o_en=1, o=0 for BIT_LOW cycles.
- BIT_H: o_en=1, o=1 for BIT_HIGH_1 cycles if the bit is 1, else BIT_HIGH_0 cycles.
REQ-013 A 6-bit bit index SHALL count 0..39. After BIT_H of index 39, go to END_L; otherwise increment the index and go to BIT_L.
REQ-014 END_L SHALL drive o=0 for BIT_LOW cycles, then release (o_en=0), pulse frame_done for one cycle, clear busy and return to IDLE.
REQ-015 From TURN through END_L, sync SHALL be ignored. A host pulling the line low mid-frame SHALL NOT restart the block.
REQ-016 Back-to-back starts SHALL be accepted: a new low on sync in IDLE is evaluated normally in the cycle after frame_done.
REQ-017 dht11_data_o and dht11_data_o_en SHALL be register outputs with no combinational path from any input.

Reset
REQ-018 While rst_n=0 the block SHALL hold:
- state = IDLE, timer = 0, bit index = 0, frame = 0, synchronizer = 1.
- dht11_data_o_en = 0, dht11_data_o = 1, busy = 0, frame_done = 0.
REQ-019 Reset asserted mid-frame SHALL release the bus in the same cycle (asynchronous) and leave no residual busy or frame_done.

Verification
REQ-020 Nominal frame:
- Stimulus: hum 0x37/0x00, temp 0x17/0x00; host drives low for 1800000 cycles, then releases.
- Response: 3000 cycles released, then 8000 low and 8000 high; bits 0x37,0x00,0x17,0x00,0x4E with high times 7000/2700; 5000 low; release; frame_done once.
REQ-021 Glitch: host low for 500 cycles, then high -> o_en stays 0, busy stays 0.
REQ-022 Checksum wrap: bytes 0xFF,0xFF,0x01,0x02 -> checksum 0x01. With err_inject=1 on the nominal data -> checksum 0xB1.
REQ-023 Snapshot: change hum_int 0x37->0x10 during bit 3 -> the transmitted frame still carries 0x37.
REQ-024 Reset mid-frame: assert rst_n=0 during bit 20 -> o_en=0 in the same cycle. Then release reset and issue a new start -> a complete correct frame is sent.
REQ-025 Host interference: the host drives low for 100 cycles during BIT_H -> the frame continues unchanged and ends with exactly one frame_done.
